// File: rtl/mux_rr_mnton_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
// Shared definitions for the round-robin M:1 registered multiplexer.
//   mux_sw()   : select/grant width for an M-channel mux, never less than 1 bit
//   MODE_RR    : mode encoding for round-robin selection
//   MODE_FIXED : mode encoding for fixed S-driven selection
// -----------------------------------------------------------------------------
package mux_pkg;

  localparam logic MODE_RR    = 1'b0;
  localparam logic MODE_FIXED = 1'b1;

  // $clog2(2) is 1 but $clog2(1) is 0; clamp so index vectors always exist.
  function automatic int mux_sw(input int m);
    return (m > 2) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/mux_rr_mnton_arb.sv
// -----------------------------------------------------------------------------
// rr_arbiter_M
// Purely combinational rotate-priority encoder. Scans the request vector
// starting one past the pointer and wrapping at M-1 -> 0 (also for M that is
// not a power of two), returning the first requesting index.
// Ports:
//   req     [M]  : per-channel request
//   ptr     [SW] : index of the most recently granted channel
//   gnt_idx [SW] : granted channel index (0 when nothing is requested)
//   gnt_vld      : a grant exists
// -----------------------------------------------------------------------------
module rr_arbiter_M
  import mux_pkg::*;
#(
  parameter  int M  = 4,
  localparam int SW = mux_sw(M)
) (
  input  logic [M-1:0]  req,
  input  logic [SW-1:0] ptr,
  output logic [SW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [SW-1:0] cand;

  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = ptr;
    for (int step = 0; step < M; step++) begin
      // Explicit wrap so non-power-of-2 M never lands on an unused index.
      cand = (cand == SW'(M - 1)) ? '0 : cand + 1'b1;
      if (!gnt_vld && req[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/mux_rr_mnton.sv
// -----------------------------------------------------------------------------
// mux_rr_mnton
// M-input, N-bit registered multiplexer with round-robin arbitration and
// valid/ready handshaking on both sides. One output register stage.
// Optional fixed-select mode is built only when MUX_RR_FIXED_EN is defined;
// otherwise mode and S are accepted but ignored.
// Ports:
//   clk      : clock, all state on rising edge
//   rst      : asynchronous active-low reset
//   en       : global enable; 0 freezes every register and drops ready_o
//   mode     : 0 round-robin, 1 fixed select by S (MUX_RR_FIXED_EN only)
//   S        : fixed-mode channel select
//   I        : flattened channel data, channel k at I[k*N +: N]
//   valid_i  : per-channel valid
//   ready_o  : per-channel accept, one-hot or zero
//   O        : registered output data
//   valid_o  : O holds valid data
//   ready_i  : downstream accept
//   grant_o  : channel index that produced O
// -----------------------------------------------------------------------------
module mux_rr_mnton
  import mux_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int M  = 4,
  localparam int SW = mux_sw(M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   S,
  input  logic [M*N-1:0]  I,
  input  logic [M-1:0]    valid_i,
  output logic [M-1:0]    ready_o,
  output logic [N-1:0]    O,
  output logic            valid_o,
  input  logic            ready_i,
  output logic [SW-1:0]   grant_o
);

  logic [N-1:0]  ch [M];
  logic [SW-1:0] rr_idx;
  logic          rr_vld;
  logic [SW-1:0] gnt_sel_p0;
  logic          gnt_vld_p0;
  logic          load_p0;

  logic [N-1:0]  data_p1;
  logic          vld_p1;
  logic [SW-1:0] gnt_p1;
  logic [SW-1:0] ptr_p1;

  for (genvar k = 0; k < M; k++) begin : g_unpack
    assign ch[k] = I[k*N +: N];
  end

  rr_arbiter_M #(.M(M)) u_arb (
    .req     (valid_i),
    .ptr     (ptr_p1),
    .gnt_idx (rr_idx),
    .gnt_vld (rr_vld)
  );

`ifdef MUX_RR_FIXED_EN
  logic fix_vld;

  // Out-of-range S simply yields no grant.
  always_comb begin
    fix_vld = 1'b0;
    if (int'(S) < M) fix_vld = valid_i[S];
  end

  assign gnt_sel_p0 = (mode == MODE_FIXED) ? S       : rr_idx;
  assign gnt_vld_p0 = (mode == MODE_FIXED) ? fix_vld : rr_vld;
`else
  logic unused_fixed;
  assign unused_fixed = ^{mode, S};

  assign gnt_sel_p0 = rr_idx;
  assign gnt_vld_p0 = rr_vld;
`endif

  // Output register can take a new beat when empty or draining this edge.
  assign load_p0 = en && (!vld_p1 || ready_i);

  always_comb begin
    ready_o = '0;
    if (load_p0 && gnt_vld_p0) ready_o[gnt_sel_p0] = 1'b1;
  end

  // ---- stage p0 -> p1 : output register and rotation pointer ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_p1 <= '0;
      vld_p1  <= 1'b0;
      gnt_p1  <= '0;
      ptr_p1  <= SW'(M - 1);
    end else if (load_p0) begin
      if (gnt_vld_p0) begin
        data_p1 <= ch[gnt_sel_p0];
        vld_p1  <= 1'b1;
        gnt_p1  <= gnt_sel_p0;
        // Fixed-mode grants also move the pointer so RR resumes fairly.
        ptr_p1  <= gnt_sel_p0;
      end else begin
        vld_p1  <= 1'b0;
      end
    end
  end

  assign O       = data_p1;
  assign valid_o = vld_p1;
  assign grant_o = gnt_p1;

endmodule

// File: tb/tb_mux_rr_mnton.sv
// -----------------------------------------------------------------------------
// tb_mux_rr_mnton
// Bench for mux_rr_mnton: a 4-channel 32-bit instance and a 3-channel 8-bit
// instance sharing clock, reset, enable, mode and S. Fixed-mode expectations
// follow MUX_RR_FIXED_EN.
// -----------------------------------------------------------------------------
module tb_mux_rr_mnton;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        mode;
  logic [1:0]  S;

  logic [127:0] i4;
  logic [3:0]   v4, rdy4;
  logic [31:0]  o4;
  logic         vo4, ri4;
  logic [1:0]   g4;

  logic [23:0]  i3;
  logic [2:0]   v3, rdy3;
  logic [7:0]   o3;
  logic         vo3, ri3;
  logic [1:0]   g3;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] d;
    logic [1:0]  g;
  } beat_t;
  beat_t sb[$];
  logic  mon_en = 1'b0;

  typedef struct {
    logic [3:0]  v;
    logic        r;
    logic        e;
    logic [3:0]  rdy;
    logic [31:0] o;
    logic        ov;
    logic [1:0]  g;
  } vec_t;
  vec_t tbl[17];

  always #5 clk = ~clk;

  mux_rr_mnton #(.N(32), .M(4)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .S(S), .I(i4),
    .valid_i(v4), .ready_o(rdy4), .O(o4), .valid_o(vo4),
    .ready_i(ri4), .grant_o(g4)
  );

  mux_rr_mnton #(.N(8), .M(3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .S(S), .I(i3),
    .valid_i(v3), .ready_o(rdy3), .O(o3), .valid_o(vo3),
    .ready_i(ri3), .grant_o(g3)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a beat leaves the DUT when valid_o && ready_i && en at an edge.
  always @(negedge clk) begin
    if (mon_en && rst && en && vo4 && ri4) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got beat %0h/g%0d, expected none", o4, g4);
      end else begin
        beat_t b;
        b = sb.pop_front();
        chk("sb_data", 64'(o4), 64'(b.d));
        chk("sb_grant", 64'(g4), 64'(b.g));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int exp3[4];
    tbl[0]  = '{4'hF, 1'b0, 1'b1, 4'b0001, 32'hA0, 1'b1, 2'd0};
    tbl[1]  = '{4'hF, 1'b0, 1'b1, 4'b0000, 32'hA0, 1'b1, 2'd0};
    tbl[2]  = '{4'hF, 1'b0, 1'b1, 4'b0000, 32'hA0, 1'b1, 2'd0};
    tbl[3]  = '{4'hF, 1'b0, 1'b1, 4'b0000, 32'hA0, 1'b1, 2'd0};
    tbl[4]  = '{4'hF, 1'b0, 1'b1, 4'b0000, 32'hA0, 1'b1, 2'd0};
    tbl[5]  = '{4'hF, 1'b0, 1'b1, 4'b0000, 32'hA0, 1'b1, 2'd0};
    tbl[6]  = '{4'hF, 1'b1, 1'b1, 4'b0010, 32'hA1, 1'b1, 2'd1};
    tbl[7]  = '{4'h0, 1'b1, 1'b1, 4'b0000, 32'hA1, 1'b0, 2'd1};
    tbl[8]  = '{4'hF, 1'b1, 1'b1, 4'b0100, 32'hA2, 1'b1, 2'd2};
    tbl[9]  = '{4'hF, 1'b1, 1'b0, 4'b0000, 32'hA2, 1'b1, 2'd2};
    tbl[10] = '{4'hF, 1'b1, 1'b0, 4'b0000, 32'hA2, 1'b1, 2'd2};
    tbl[11] = '{4'h9, 1'b1, 1'b1, 4'b1000, 32'hA3, 1'b1, 2'd3};
    tbl[12] = '{4'h9, 1'b1, 1'b1, 4'b0001, 32'hA0, 1'b1, 2'd0};
    tbl[13] = '{4'h6, 1'b0, 1'b1, 4'b0000, 32'hA0, 1'b1, 2'd0};
    tbl[14] = '{4'h6, 1'b1, 1'b1, 4'b0010, 32'hA1, 1'b1, 2'd1};
    tbl[15] = '{4'h0, 1'b1, 1'b1, 4'b0000, 32'hA1, 1'b0, 2'd1};
    tbl[16] = '{4'h0, 1'b0, 1'b1, 4'b0000, 32'hA1, 1'b0, 2'd1};
    exp3 = '{0, 2, 0, 2};

    rst = 1'b0; en = 1'b0; mode = 1'b0; S = 2'd0;
    i4 = {32'hA3, 32'hA2, 32'hA1, 32'hA0}; v4 = '0; ri4 = 1'b0;
    i3 = {8'h32, 8'h31, 8'h30};            v3 = '0; ri3 = 1'b1;

    // Reset state
    #12;
    chk("rst_O", 64'(o4), 64'h0);
    chk("rst_valid_o", 64'(vo4), 64'h0);
    chk("rst_grant_o", 64'(g4), 64'h0);
    chk("rst_ready_o", 64'(rdy4), 64'h0);
    chk("rst_valid_o_m3", 64'(vo3), 64'h0);

    // Idle after release
    @(posedge clk); #1;
    rst = 1'b1; en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("idle_O", 64'(o4), 64'h0);
      chk("idle_valid_o", 64'(vo4), 64'h0);
      chk("idle_grant_o", 64'(g4), 64'h0);
      chk("idle_ready_o", 64'(rdy4), 64'h0);
    end

    // Round-robin fairness, all channels valid, continuous drain
    for (int k = 0; k < 8; k++) sb.push_back('{32'hA0 + 32'(k % 4), 2'(k % 4)});
    v4 = 4'hF; ri4 = 1'b1; mon_en = 1'b1;
    #1;
    chk("rr_first_ready", 64'(rdy4), 64'b0001);
    repeat (8) @(posedge clk);
    #1;
    v4 = 4'h0;
    @(posedge clk); #1;
    chk("rr_drain_valid_o", 64'(vo4), 64'h0);
    chk("rr_hold_O", 64'(o4), 64'hA3);
    chk("rr_hold_grant", 64'(g4), 64'h3);
    chk("rr_sb_empty", 64'(sb.size()), 64'h0);

    // Table: back-pressure, enable freeze, sparse requests
    for (int t = 0; t < 17; t++) begin
      v4 = tbl[t].v; ri4 = tbl[t].r; en = tbl[t].e;
      if (tbl[t].rdy != 4'b0000) sb.push_back('{tbl[t].o, tbl[t].g});
      #1;
      chk($sformatf("tbl%0d_ready_o", t), 64'(rdy4), 64'(tbl[t].rdy));
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_O", t), 64'(o4), 64'(tbl[t].o));
      chk($sformatf("tbl%0d_valid_o", t), 64'(vo4), 64'(tbl[t].ov));
      chk($sformatf("tbl%0d_grant_o", t), 64'(g4), 64'(tbl[t].g));
    end
    chk("tbl_sb_empty", 64'(sb.size()), 64'h0);
    mon_en = 1'b0;
    en = 1'b1;

    // M=3 sparse requests with wrap, then enable freeze
    v3 = 3'b101;
    for (int b = 0; b < 4; b++) begin
      #1;
      chk("m3_ready_o", 64'(rdy3), 64'(1 << exp3[b]));
      @(posedge clk); #1;
      chk("m3_grant_o", 64'(g3), 64'(exp3[b]));
      chk("m3_O", 64'(o3), 64'(8'h30 + 8'(exp3[b])));
      chk("m3_valid_o", 64'(vo3), 64'h1);
    end
    en = 1'b0;
    repeat (2) begin
      #1;
      chk("m3_freeze_ready_o", 64'(rdy3), 64'h0);
      @(posedge clk); #1;
      chk("m3_freeze_O", 64'(o3), 64'h32);
      chk("m3_freeze_grant", 64'(g3), 64'h2);
      chk("m3_freeze_valid", 64'(vo3), 64'h1);
    end
    en = 1'b1; v3 = 3'b111;
    #1;
    chk("m3_wrap_ready_o", 64'(rdy3), 64'b001);
    @(posedge clk); #1;
    chk("m3_wrap_grant", 64'(g3), 64'h0);
    chk("m3_wrap_O", 64'(o3), 64'h30);
    v3 = 3'b110;
    @(posedge clk); #1;
    chk("m3_next_grant", 64'(g3), 64'h1);
    v3 = 3'b000;

    // Async reset in the middle of a stream
    v4 = 4'hF; ri4 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ar_pre_valid", 64'(vo4), 64'h1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_O", 64'(o4), 64'h0);
    chk("ar_valid_o", 64'(vo4), 64'h0);
    chk("ar_grant_o", 64'(g4), 64'h0);
    @(posedge clk); #1;
    chk("ar_held_valid", 64'(vo4), 64'h0);
    rst = 1'b1;
    #1;
    chk("ar_first_ready", 64'(rdy4), 64'b0001);
    @(posedge clk); #1;
    chk("ar_first_O", 64'(o4), 64'hA0);
    chk("ar_first_grant", 64'(g4), 64'h0);
    chk("ar_first_valid", 64'(vo4), 64'h1);

    // Mode / S behaviour
    mode = 1'b1; S = 2'd2; v4 = 4'hF;
`ifdef MUX_RR_FIXED_EN
    #1;
    chk("fx_ready_o", 64'(rdy4), 64'b0100);
    repeat (2) begin
      @(posedge clk); #1;
      chk("fx_O", 64'(o4), 64'hA2);
      chk("fx_grant", 64'(g4), 64'h2);
      chk("fx_valid", 64'(vo4), 64'h1);
    end
    v4 = 4'b1011;
    #1;
    chk("fx_nogrant_ready", 64'(rdy4), 64'h0);
    @(posedge clk); #1;
    chk("fx_nogrant_valid", 64'(vo4), 64'h0);
    chk("fx_nogrant_O", 64'(o4), 64'hA2);
    S = 2'd3; v3 = 3'b111;
    #1;
    chk("fx_m3_oob_ready", 64'(rdy3), 64'h0);
    chk("fx_s3_ready", 64'(rdy4), 64'b1000);
    mode = 1'b0;
    #1;
    chk("fx_back_rr_ready", 64'(rdy4), 64'b1000);
    chk("fx_back_rr_m3", 64'(rdy3), 64'b001);
`else
    #1;
    chk("nofx_ready_o", 64'(rdy4), 64'b0010);
    @(posedge clk); #1;
    chk("nofx_O", 64'(o4), 64'hA1);
    chk("nofx_grant", 64'(g4), 64'h1);
    S = 2'd3; v3 = 3'b111;
    #1;
    chk("nofx_m3_ready", 64'(rdy3), 64'b001);
`endif
    mode = 1'b0; v4 = '0; v3 = '0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
